// File: rtl/vga_timing_delay.sv
// vga_timing_delay: DEPTH-cycle delay of the VGA timing bus plus one RGB channel, held idle until the pipe is full.
// Define VGA_TIMING_DELAY_FRAME_LOCK_EN to hold the outputs idle until the first frame-start word (hcount=0, vcount=0).
module vga_timing_delay #(
   parameter int DEPTH = 1,
   parameter int CNT_W = 11,
   parameter int RGB_W = 12
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             hs_in,
   input  logic             vs_in,
   input  logic             hblnk_in,
   input  logic             vblnk_in,
   input  logic [CNT_W-1:0] hcount_in,
   input  logic [CNT_W-1:0] vcount_in,
   input  logic [RGB_W-1:0] rgb_in,
   output logic             hs_out,
   output logic             vs_out,
   output logic             hblnk,
   output logic             vblnk,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic [RGB_W-1:0] rgb_out,
   output logic             out_valid
);
   localparam int W = 4 + 2*CNT_W + RGB_W;
   localparam int CW = $clog2(DEPTH+1);
   localparam int HB = W - 3;
   localparam int VB = W - 4;
   localparam logic [CW-1:0] LAST = CW'(DEPTH-1);
   // Word layout {hs, vs, hblnk, vblnk, hcount, vcount, rgb}; idle is blanked with everything else low.
   localparam logic [W-1:0] IDLE = {4'b0011, {(W-4){1'b0}}};

   typedef enum logic [1:0] {
      FILL = 2'd0,
      RUN = 2'd1
`ifdef VGA_TIMING_DELAY_FRAME_LOCK_EN
      , WAIT_FRAME = 2'd2
`endif
   } state_t;

   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic valid_q, valid_d;
   logic [W-1:0] pipe_q [DEPTH];
   logic [W-1:0] pipe_d [DEPTH];
   logic [W-1:0] tap [DEPTH];
   logic [W-1:0] live_w;

   always_comb begin
      tap[0] = {hs_in, vs_in, hblnk_in, vblnk_in, hcount_in, vcount_in, rgb_in};
      for (int i = 1; i < DEPTH; i++) tap[i] = pipe_q[i-1];
   end

   always_comb begin
      cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
      state_d = state_q;
`ifdef VGA_TIMING_DELAY_FRAME_LOCK_EN
      // The word about to be loaded decides the lock, so a frame start already in the pipe costs no extra frame.
      if ((state_q == FILL && cnt_q == LAST) || state_q == WAIT_FRAME)
         state_d = (tap[DEPTH-1][W-5 -: 2*CNT_W] == '0) ? RUN : WAIT_FRAME;
`else
      if (state_q == FILL && cnt_q == LAST) state_d = RUN;
`endif
      valid_d = state_d == RUN;
   end

   always_comb begin
      live_w = tap[DEPTH-1];
      if (live_w[HB] | live_w[VB]) live_w[RGB_W-1:0] = '0;
      for (int i = 0; i < DEPTH; i++) pipe_d[i] = tap[i];
      pipe_d[DEPTH-1] = valid_d ? live_w : IDLE;
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q <= FILL;
         cnt_q <= '0;
         valid_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= IDLE;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         valid_q <= valid_d;
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= pipe_d[i];
      end
   end

   assign {hs_out, vs_out, hblnk, vblnk, hcount, vcount, rgb_out} = pipe_q[DEPTH-1];
   assign out_valid = valid_q;
endmodule

// File: doc/vga_timing_delay.md
# vga_timing_delay

Parametrised pipeline delay for the VGA timing bus (hsync, vsync, hblnk, vblnk, hcount, vcount) plus one RGB pixel channel. It sits between a drawing stage and the next consumer, and keeps timing aligned with pixel data that took DEPTH clocks to produce. It adds pipeline-fill tracking, idle-value masking of un-filled outputs, RGB blank gating, and an optional frame-start lock.

## Interface
Parameters:
- DEPTH, 1: latency in pclk cycles; legal range 1..16.
- CNT_W, 11: width of hcount/vcount.
- RGB_W, 12: width of the RGB channel.

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  reset: synchronous, active-high.
- hs_in, vs_in  in  1  sync inputs, passed through as-is (polarity untouched).
- hblnk_in, vblnk_in  in  1  blanking inputs.
- hcount_in, vcount_in  in  CNT_W  pixel/line counters.
- rgb_in  in  RGB_W  pixel colour aligned with the timing inputs.
- hs_out, vs_out  out  1  delayed syncs.
- hblnk, vblnk  out  1  delayed blanking.
- hcount, vcount  out  CNT_W  delayed counters.
- rgb_out  out  RGB_W  delayed colour, zero-gated during blanking.
- out_valid  out  1  high while outputs carry real delayed data (state RUN).

## Operation
- A DEPTH-stage register chain carries all inputs. Outputs come straight from registers, with no combinational path from inputs.
- Idle output values: hs_out=0, vs_out=0, hblnk=1, vblnk=1, hcount=0, vcount=0, rgb_out=0, out_valid=0.
- Fill counter, width $clog2(DEPTH+1):
  - Cleared by rst.
  - Increments once per non-reset edge.
  - Saturates at DEPTH-1; it never wraps.
- States:
  - FILL: outputs at idle values. On the edge where the counter equals DEPTH-1, the state moves to RUN. With FRAME_LOCK compiled in, it moves to WAIT_FRAME instead.
  - WAIT_FRAME (FRAME_LOCK only): outputs stay at idle values. On the edge where the word being loaded into the outputs has hcount==0 and vcount==0, that word is loaded unmasked and the state moves to RUN.
  - RUN: outputs are the delayed inputs. RUN is left only via rst.
- RGB gating: in RUN, rgb_out is 0 whenever the delayed hblnk or vblnk is 1; otherwise it is the delayed rgb_in.
- Counters are passed bit-exact; no arithmetic is applied and no wrap is checked.

## Timing
- Reset: while rst is high at an edge, every output and every pipeline stage takes its idle value after that edge, and the state becomes FILL.
- Latency: an input sampled at non-reset edge e appears on the outputs immediately after edge e+DEPTH-1. For DEPTH=1 this is a single register stage.
- Without FRAME_LOCK: out_valid rises after the DEPTH-th edge following rst release. That edge also presents the first post-reset input word.
- Input words sampled while rst is high are discarded; they never reach the outputs.
- rst asserted mid-RUN: outputs go to idle values at that edge and refill exactly as at power-up. No stale stage contents survive.
- rst held for several cycles: the fill counter stays at 0 for the whole time.
- WAIT_FRAME with a frame-start word already in the pipeline at fill completion: lock occurs on that word, with no extra frame of delay.
- WAIT_FRAME with no frame start ever arriving: the state is held indefinitely and the outputs stay idle.

## Configuration
- Macro VGA_TIMING_DELAY_FRAME_LOCK_EN.
- Defined: the WAIT_FRAME state exists. Outputs and out_valid only go live starting at the word carrying hcount=0, vcount=0, so downstream blocks never see a partial first frame.
- Undefined: WAIT_FRAME is not built. FILL goes directly to RUN, and out_valid rises exactly DEPTH edges after rst release.

## Test plan
- DEPTH=1, no lock, ramping hcount_in=0,1,2…: after rst release, hcount=0 after the first edge and out_valid=1 after edge 1. hs/vs/blnk follow the inputs with 1-cycle delay.
- DEPTH=4, no lock: out_valid=0 for edges 1..3 with outputs idle (hblnk=1, rgb_out=0). After edge 4 the outputs equal the inputs from edge 1 and out_valid=1. Thereafter latency is constant at 4.
- RGB gating, DEPTH=3: drive rgb_in=12'hFFF with hblnk_in toggling. rgb_out=0 exactly on the delayed blanked cycles and 12'hFFF otherwise.
- Mid-run reset, DEPTH=4: assert rst for 2 cycles during RUN. Outputs are idle after the first rst edge, and the pre-reset words never appear. out_valid returns 4 edges after release.
- FRAME_LOCK defined, DEPTH=2, stream starting at hcount=100, vcount=50: outputs stay idle and out_valid=0 until the delayed word with hcount=0, vcount=0. That word is output with out_valid=1, and every later word is passed.
- FRAME_LOCK defined, frame start at the first post-reset input: lock is taken at fill completion, with out_valid=1 after edge DEPTH.
